// File: rtl/membus_core_responder_if.sv
// Pulse-and-level memory bus between a processor's request logic (master)
// and one core memory module (slave).
interface membus_core_responder_if #(
  parameter int ADDR_W = 12,
  parameter int WORD_W = 36
);
  logic              sel;
  logic              rq_cyc;
  logic              rd_rq;
  logic              wr_rq;
  logic [ADDR_W-1:0] addr;
  logic              wr_rs;
  logic [WORD_W-1:0] mb_in;
  logic              addr_ack;
  logic              rd_rs;
  logic [WORD_W-1:0] mb_out;
  logic              busy;
  logic              tmo;

  modport master (
    output sel, rq_cyc, rd_rq, wr_rq, addr, wr_rs, mb_in,
    input  addr_ack, rd_rs, mb_out, busy, tmo
  );

  modport slave (
    input  sel, rq_cyc, rd_rq, wr_rq, addr, wr_rs, mb_in,
    output addr_ack, rd_rs, mb_out, busy, tmo
  );
endinterface

// File: rtl/membus_core_responder.sv
// Core memory module responder: accepts a bus cycle, acknowledges the address,
// returns read data and accepts write data on clock-counted core timing.
module membus_core_responder #(
  parameter int ADDR_W  = 12,
  parameter int WORD_W  = 36,
  parameter int ACK_DLY = 4,
  parameter int RD_DLY  = 10,
  parameter int MB_HOLD = 4,
  parameter int WR_TMO  = 500,
  parameter int CYC_MIN = 50
) (
  input  logic                   clk,
  input  logic                   reset,
  membus_core_responder_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_ACK, S_RD, S_WAIT_WR, S_RECOVER} state_t;

  localparam int          HOLD_W = $clog2(MB_HOLD + 1);
  localparam logic [15:0] ACK_AT = 16'(ACK_DLY);
  localparam logic [15:0] RD_AT  = 16'(ACK_DLY + RD_DLY);
  localparam logic [15:0] TMO_WO = 16'(ACK_DLY + 1 + WR_TMO);
  localparam logic [15:0] TMO_RW = 16'(ACK_DLY + RD_DLY + 1 + WR_TMO);
  // Leaving on the edge that ends clock CYC_MIN-1 makes clock CYC_MIN the first idle one
  localparam logic [15:0] REC_AT = 16'(CYC_MIN - 1);

  state_t              r_state, w_state_nxt;
  logic [15:0]         r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_rd, r_wr;
  logic [HOLD_W-1:0]   r_hold;
  logic [WORD_W-1:0]   r_mb;
  logic [WORD_W-1:0]   r_rdata;
  logic [WORD_W-1:0]   r_mem [0:(1<<ADDR_W)-1];

  logic                w_accept, w_ack, w_rs, w_write, w_tmo;
  logic [15:0]         w_tmo_at;

  assign w_tmo_at = r_rd ? TMO_RW : TMO_WO;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ack       = 1'b0;
    w_rs        = 1'b0;
    w_write     = 1'b0;
    w_tmo       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.sel && bus.rq_cyc && (bus.rd_rq || bus.wr_rq)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        if (!bus.rq_cyc) begin
          w_state_nxt = S_RECOVER;
        end else if (r_cnt == ACK_AT) begin
          w_ack       = 1'b1;
          w_state_nxt = r_rd ? S_RD : S_WAIT_WR;
        end
      end
      S_RD: begin
        if (!bus.rq_cyc) begin
          w_state_nxt = S_RECOVER;
        end else if (r_cnt == RD_AT) begin
          w_rs        = 1'b1;
          w_state_nxt = r_wr ? S_WAIT_WR : S_RECOVER;
        end
      end
      S_WAIT_WR: begin
        // A write strobe beats both an abort and a timeout on the same clock
        if (bus.wr_rs) begin
          w_write     = 1'b1;
          w_state_nxt = S_RECOVER;
        end else if (!bus.rq_cyc) begin
          w_state_nxt = S_RECOVER;
        end else if (r_cnt == w_tmo_at) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (r_cnt >= REC_AT && !bus.rq_cyc) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt  <= '0;
        r_addr <= bus.addr;
        r_rd   <= bus.rd_rq;
        r_wr   <= bus.wr_rq;
      end else if (r_state != S_IDLE && r_cnt != '1) begin
        r_cnt <= r_cnt + 16'd1;
      end
      // Hold window runs on its own so an abort cannot truncate it
      if (w_rs)             r_hold <= HOLD_W'(MB_HOLD - 1);
      else if (r_hold != 0) r_hold <= r_hold - HOLD_W'(1);
    end
  end

  // Core array is non-volatile: no reset on storage or its read path
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[r_addr];
    if (w_rs)    r_mb <= r_rdata;
    if (w_write) r_mem[r_addr] <= bus.mb_in;
  end

  assign bus.addr_ack = w_ack;
  assign bus.rd_rs    = w_rs;
  assign bus.tmo      = w_tmo;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.mb_out   = w_rs ? r_rdata : ((r_hold != 0) ? r_mb : '0);

endmodule

// File: tb/tb_membus_core_responder.sv
// Directed bench for membus_core_responder: read, write, read-modify-write,
// write timeout, early abort and asynchronous reset, with hand-computed timing.
module tb_membus_core_responder;

  logic clk;
  logic reset;

  membus_core_responder_if #(.ADDR_W(12), .WORD_W(36)) bus ();

  membus_core_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Per-cycle observations of the most recent bus cycle (clock 0 = acceptance)
  logic [35:0] obs_mb [0:599];
  int ack_first, ack_n, rs_first, rs_n, tmo_first, tmo_n, free_clk;
  logic [35:0] rs_data;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  task automatic run_cycle(input logic [11:0] a, input logic rd, input logic wr,
                           input logic [35:0] wd, input int wr_at,
                           input int drop_at, input int limit);
    ack_first = -1; ack_n = 0; rs_first = -1; rs_n = 0;
    tmo_first = -1; tmo_n = 0; free_clk = -1; rs_data = '0;
    @(posedge clk); #1;
    bus.sel = 1'b1; bus.rq_cyc = 1'b1; bus.rd_rq = rd; bus.wr_rq = wr;
    bus.addr = a; bus.wr_rs = 1'b0; bus.mb_in = wd;
    @(posedge clk); #1;
    bus.rd_rq = 1'b0; bus.wr_rq = 1'b0;
    for (int k = 0; k < limit; k++) begin
      bus.rq_cyc = (k < drop_at);
      bus.wr_rs  = (k == wr_at);
      @(negedge clk);
      obs_mb[k] = bus.mb_out;
      if (bus.addr_ack) begin if (ack_first < 0) ack_first = k; ack_n++; end
      if (bus.rd_rs) begin if (rs_first < 0) begin rs_first = k; rs_data = bus.mb_out; end rs_n++; end
      if (bus.tmo) begin if (tmo_first < 0) tmo_first = k; tmo_n++; end
      if (!bus.busy && free_clk < 0) free_clk = k;
      @(posedge clk); #1;
    end
    bus.rq_cyc = 1'b0; bus.wr_rs = 1'b0; bus.sel = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    bus.sel = 1'b1; bus.rq_cyc = 1'b1; bus.rd_rq = 1'b1; bus.wr_rq = 1'b0;
    bus.addr = '0; bus.wr_rs = 1'b0; bus.mb_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vec_cnt++; if ({bus.addr_ack, bus.rd_rs, bus.tmo} !== 3'b000) begin err_cnt++; $display("FAIL reset_pulses: got %b want 000", {bus.addr_ack, bus.rd_rs, bus.tmo}); end
    vec_cnt++; if (bus.mb_out !== 36'o0) begin err_cnt++; $display("FAIL reset_mb: got %o want 0", bus.mb_out); end
    bus.sel = 1'b0; bus.rq_cyc = 1'b0; bus.rd_rq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write;
    run_cycle(12'o1234, 1'b0, 1'b1, 36'o123456701234, 6, 20, 60);
    vec_cnt++; if (ack_first !== 4) begin err_cnt++; $display("FAIL wr_ack_clk: got %0d want 4", ack_first); end
    vec_cnt++; if (ack_n !== 1) begin err_cnt++; $display("FAIL wr_ack_count: got %0d want 1", ack_n); end
    vec_cnt++; if (rs_n !== 0) begin err_cnt++; $display("FAIL wr_no_rs: got %0d want 0", rs_n); end
    vec_cnt++; if (tmo_n !== 0) begin err_cnt++; $display("FAIL wr_no_tmo: got %0d want 0", tmo_n); end
    vec_cnt++; if (free_clk !== 50) begin err_cnt++; $display("FAIL wr_busy_fall: got %0d want 50", free_clk); end
    // wr_rs together with rq_cyc dropping: the write is still performed
    run_cycle(12'd5, 1'b0, 1'b1, 36'o777000777000, 6, 6, 60);
    vec_cnt++; if (free_clk !== 50) begin err_cnt++; $display("FAIL wr5_busy_fall: got %0d want 50", free_clk); end
    run_cycle(12'd7, 1'b0, 1'b1, 36'o1, 6, 20, 60);
    vec_cnt++; if (ack_first !== 4) begin err_cnt++; $display("FAIL wr7_ack_clk: got %0d want 4", ack_first); end
  endtask

  task automatic test_read;
    run_cycle(12'o1234, 1'b1, 1'b0, 36'o0, -1, 20, 60);
    vec_cnt++; if (ack_first !== 4) begin err_cnt++; $display("FAIL rd_ack_clk: got %0d want 4", ack_first); end
    vec_cnt++; if (rs_first !== 14) begin err_cnt++; $display("FAIL rd_rs_clk: got %0d want 14", rs_first); end
    vec_cnt++; if (rs_n !== 1) begin err_cnt++; $display("FAIL rd_rs_count: got %0d want 1", rs_n); end
    vec_cnt++; if (obs_mb[13] !== 36'o0) begin err_cnt++; $display("FAIL rd_mb_pre: got %o want 0", obs_mb[13]); end
    for (int k = 14; k <= 17; k++) begin
      vec_cnt++; if (obs_mb[k] !== 36'o123456701234) begin err_cnt++; $display("FAIL rd_mb_hold clk %0d: got %o want 123456701234", k, obs_mb[k]); end
    end
    vec_cnt++; if (obs_mb[18] !== 36'o0) begin err_cnt++; $display("FAIL rd_mb_post: got %o want 0", obs_mb[18]); end
    vec_cnt++; if (free_clk !== 50) begin err_cnt++; $display("FAIL rd_busy_fall: got %0d want 50", free_clk); end
    run_cycle(12'd5, 1'b1, 1'b0, 36'o0, -1, 20, 60);
    vec_cnt++; if (rs_data !== 36'o777000777000) begin err_cnt++; $display("FAIL rd5_data: got %o want 777000777000", rs_data); end
  endtask

  task automatic test_rmw;
    run_cycle(12'd7, 1'b1, 1'b1, 36'o2, 16, 90, 100);
    vec_cnt++; if (rs_first !== 14) begin err_cnt++; $display("FAIL rmw_rs_clk: got %0d want 14", rs_first); end
    vec_cnt++; if (rs_data !== 36'o1) begin err_cnt++; $display("FAIL rmw_old_data: got %o want 1", rs_data); end
    vec_cnt++; if (ack_n !== 1) begin err_cnt++; $display("FAIL rmw_single_accept: got %0d acks want 1", ack_n); end
    vec_cnt++; if (free_clk !== 91) begin err_cnt++; $display("FAIL rmw_busy_fall: got %0d want 91", free_clk); end
    run_cycle(12'd7, 1'b1, 1'b0, 36'o0, -1, 20, 60);
    vec_cnt++; if (rs_data !== 36'o2) begin err_cnt++; $display("FAIL rmw_new_data: got %o want 2", rs_data); end
  endtask

  task automatic test_timeout;
    run_cycle(12'd5, 1'b0, 1'b1, 36'o5, -1, 530, 560);
    vec_cnt++; if (tmo_first !== 505) begin err_cnt++; $display("FAIL tmo_clk: got %0d want 505", tmo_first); end
    vec_cnt++; if (tmo_n !== 1) begin err_cnt++; $display("FAIL tmo_count: got %0d want 1", tmo_n); end
    vec_cnt++; if (free_clk !== 531) begin err_cnt++; $display("FAIL tmo_busy_fall: got %0d want 531", free_clk); end
    run_cycle(12'd5, 1'b1, 1'b0, 36'o0, -1, 20, 60);
    vec_cnt++; if (rs_data !== 36'o777000777000) begin err_cnt++; $display("FAIL tmo_mem_kept: got %o want 777000777000", rs_data); end
  endtask

  task automatic test_abort;
    // rq_cyc dropped in ACK; the later wr_rs lands in RECOVER and is ignored
    run_cycle(12'd5, 1'b0, 1'b1, 36'o111, 6, 2, 60);
    vec_cnt++; if (ack_n !== 0) begin err_cnt++; $display("FAIL abort_no_ack: got %0d want 0", ack_n); end
    vec_cnt++; if (tmo_n !== 0) begin err_cnt++; $display("FAIL abort_no_tmo: got %0d want 0", tmo_n); end
    vec_cnt++; if (free_clk !== 50) begin err_cnt++; $display("FAIL abort_busy_fall: got %0d want 50", free_clk); end
    run_cycle(12'd5, 1'b1, 1'b0, 36'o0, -1, 20, 60);
    vec_cnt++; if (rs_data !== 36'o777000777000) begin err_cnt++; $display("FAIL abort_mem_kept: got %o want 777000777000", rs_data); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk); #1;
    bus.sel = 1'b1; bus.rq_cyc = 1'b1; bus.rd_rq = 1'b0; bus.wr_rq = 1'b1;
    bus.addr = 12'd9; bus.wr_rs = 1'b0; bus.mb_in = 36'o666;
    @(posedge clk); #1;
    bus.wr_rq = 1'b0;
    repeat (10) @(posedge clk);
    #5;
    vec_cnt++; if (bus.busy !== 1'b1) begin err_cnt++; $display("FAIL rstmid_pre_busy: got %b want 1", bus.busy); end
    reset = 1'b0;
    #1;
    vec_cnt++; if (bus.busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
    vec_cnt++; if ({bus.addr_ack, bus.rd_rs, bus.tmo} !== 3'b000) begin err_cnt++; $display("FAIL rstmid_pulses: got %b want 000", {bus.addr_ack, bus.rd_rs, bus.tmo}); end
    vec_cnt++; if (bus.mb_out !== 36'o0) begin err_cnt++; $display("FAIL rstmid_mb: got %o want 0", bus.mb_out); end
    bus.sel = 1'b0; bus.rq_cyc = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    run_cycle(12'o1234, 1'b1, 1'b0, 36'o0, -1, 20, 60);
    vec_cnt++; if (rs_first !== 14) begin err_cnt++; $display("FAIL rstmid_rs_clk: got %0d want 14", rs_first); end
    vec_cnt++; if (rs_data !== 36'o123456701234) begin err_cnt++; $display("FAIL rstmid_mem_kept: got %o want 123456701234", rs_data); end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_rmw;
    test_timeout;
    test_abort;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/membus_core_responder.md
Name: membus_core_responder

Overview:
- Memory-side responder for the pulse-and-level memory bus driven by the processor's request logic.
- Models one core memory module: accepts a cycle request, returns the address-acknowledge pulse, returns the read-restart pulse with data, and accepts the write-restart pulse with data.
- Core timing (acknowledge delay, read access, minimum cycle time) is produced by counting 50 MHz clocks.
- Read-modify-write cycles are supported.

Parameters:
- ADDR_W, 12, address width; the memory holds 2^ADDR_W words.
- WORD_W, 36, data word width.
- ACK_DLY, 4, clocks from acceptance to the addr_ack pulse.
- RD_DLY, 10, clocks from addr_ack to the rd_rs pulse.
- MB_HOLD, 4, clocks mb_out stays valid, starting on the rd_rs cycle.
- WR_TMO, 500, clocks waited in WAIT_WR for wr_rs before abort.
- CYC_MIN, 50, minimum clocks from acceptance until the next acceptance is possible.

Ports:
- clk  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-low reset.
- sel  in  1  level: this module is addressed.
- rq_cyc  in  1  level: initiator requests or holds a cycle.
- rd_rq  in  1  level: cycle includes a read.
- wr_rq  in  1  level: cycle includes a write.
- addr  in  ADDR_W  word address, valid while rq_cyc is high.
- wr_rs  in  1  one-clock pulse: write data valid on mb_in.
- mb_in  in  WORD_W  write data, sampled on the wr_rs cycle.
- addr_ack  out  1  one-clock pulse: request accepted, address latched.
- rd_rs  out  1  one-clock pulse: read data valid.
- mb_out  out  WORD_W  read data during the hold window, zero otherwise.
- busy  out  1  high whenever state is not IDLE.
- tmo  out  1  one-clock pulse on write timeout abort.

Behaviour:
- All inputs are synchronous to clk and are sampled on rising edges.
- Reset (reset low, asynchronous):
  - state goes to IDLE; cycle counter, hold counter and latched address/flags are cleared.
  - addr_ack, rd_rs, tmo, busy = 0; mb_out = 0.
  - Memory contents are NOT cleared; core is non-volatile across reset.
  - Reset in the middle of a cycle abandons it. No write occurs unless the write clock edge itself completed before reset asserted.
- Cycle counter cnt: 16 bits, cleared on acceptance, +1 per clock outside IDLE, saturates at all-ones.
- IDLE:
  - Accept when sel & rq_cyc & (rd_rq | wr_rq).
  - On acceptance: latch addr, rd = rd_rq, wr = wr_rq; cnt = 0; go to ACK.
  - rd_rq and wr_rq are ignored after acceptance.
- ACK:
  - When cnt == ACK_DLY, pulse addr_ack for one clock.
  - Then go to RD if rd is set, otherwise to WAIT_WR.
- RD:
  - When cnt == ACK_DLY + RD_DLY: pulse rd_rs, load mb_out with mem[addr], and start the hold count.
  - mb_out holds that word for exactly MB_HOLD clocks (the rd_rs cycle included), then returns to 0. The hold runs independently of the state.
  - Core read is destructive; the restore is implicit, so mem[addr] is unchanged by a read.
  - After the rd_rs cycle, go to WAIT_WR if wr is set, otherwise to RECOVER.
- WAIT_WR:
  - On wr_rs: mem[addr] <= mb_in in the same clock, then go to RECOVER.
  - A read-modify-write therefore stores new data; a read-only cycle leaves the old data.
  - Timeout: if WR_TMO clocks pass after entry with no wr_rs, pulse tmo, write nothing, and go to RECOVER.
- Abort: rq_cyc low in ACK, RD or WAIT_WR sends the FSM to RECOVER at once.
  - No further addr_ack, rd_rs or write occurs.
  - A read hold already started completes normally.
- RECOVER: return to IDLE when cnt >= CYC_MIN and rq_cyc == 0.
  - The initiator must drop rq_cyc before a second cycle can be accepted.
  - This prevents a double acceptance of a single held request.
- Simultaneous events:
  - wr_rs on the same clock as rq_cyc low in WAIT_WR: the write wins and is performed.
  - wr_rs on the same clock as the timeout: the write wins and tmo is not pulsed.
  - wr_rs outside WAIT_WR is ignored.
- Address wrap-around is not applicable: addr is exactly ADDR_W bits, and every value is a valid word.
- addr_ack, rd_rs and tmo are each high for exactly one clock per event.

Test Plan:
- Read: preload mem[0o1234] = 0o123456701234; hold sel=1, rq_cyc=1, rd_rq=1.
  - Required: addr_ack at clock 4 after acceptance and rd_rs at clock 14.
  - mb_out = 0o123456701234 for clocks 14-17 and 0 at clock 18.
  - Drop rq_cyc at clock 20: busy falls at clock 50.
- Write: addr=5, wr_rq=1; after addr_ack, pulse wr_rs with mb_in = 0o777000777000.
  - Required: a following read of addr 5 returns 0o777000777000.
- Read-modify-write: mem[7] = 1; rd_rq=wr_rq=1.
  - Required: rd_rs presents 1; wr_rs with mb_in=2 leaves mem[7] = 2.
  - A second cycle is not accepted while rq_cyc is held high.
- Timeout: write cycle with no wr_rs.
  - Required: tmo pulses once, 500 clocks after WAIT_WR entry; mem unchanged.
  - Same case with rq_cyc dropped at clock 2: no addr_ack and no write.
- Reset: assert reset low during WAIT_WR.
  - Required: all outputs 0 and busy 0 immediately (asynchronous); previously written data still readable after reset is released.
